// File: rtl/bus_arbiter_rr.sv
// Shares one pipelined read port among NUM_CHANNELS requesters.
// Arbitration is fixed-priority or round-robin; each channel has at most one read in flight.
module bus_arbiter_rr #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CHANNELS-1:0]               data_req,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data,
  output logic [NUM_CHANNELS-1:0]               data_rdy,
  output logic [ADDRESS_WIDTH-1:0]              mem_data_addr,
  output logic                                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0]                 mem_data
);

  // Handshake: a channel raises data_req with a stable data_addr and holds both until
  // data_rdy is seen; dropping data_req then retires the result, while dropping it
  // before data_rdy aborts the outstanding read and its return is discarded.

  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]            data_rdy_q, data_rdy_d;
  logic [NUM_CHANNELS-1:0]            inflight_q, inflight_d;
  logic [NUM_CHANNELS-1:0]            abort_q, abort_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [MEM_LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]                   tag_ch_q [MEM_LATENCY];
  logic [PTR_W-1:0]                   tag_ch_d [MEM_LATENCY];

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_ch;
  logic                    ret_vld;
  logic [PTR_W-1:0]        ret_ch;

  assign eligible = data_req & ~data_rdy_q & ~inflight_q;
  assign ret_vld  = tag_vld_q[MEM_LATENCY-1];
  assign ret_ch   = tag_ch_q[MEM_LATENCY-1];

  // Descending scan so the candidate closest to the search start is the one that sticks.
  always_comb begin : grant_pick
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      idx = (PRIORITY_MODE == 0) ? k : int'(rr_ptr_q) + k;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = PTR_W'(idx);
      end
    end
  end

  assign mem_rd_en     = grant_vld & ~rst;
  assign mem_data_addr = (grant_vld && !rst) ?
                         data_addr[int'(grant_ch)*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;

  always_comb begin
    abort_d    = abort_q | (inflight_q & ~data_req);
    inflight_d = inflight_q;
    data_rdy_d = data_rdy_q & data_req;
    data_d     = data_q;
    rr_ptr_d   = rr_ptr_q;
    // A return for an aborted channel only retires the slot.
    if (ret_vld) begin
      inflight_d[ret_ch] = 1'b0;
      if (!abort_d[ret_ch]) begin
        data_rdy_d[ret_ch]                                 = 1'b1;
        data_d[int'(ret_ch)*DATA_WIDTH +: DATA_WIDTH]      = mem_data;
      end
      abort_d[ret_ch] = 1'b0;
    end
    if (grant_vld) begin
      inflight_d[grant_ch] = 1'b1;
      rr_ptr_d = (int'(grant_ch) == NUM_CHANNELS - 1) ? '0 : grant_ch + 1'b1;
    end
    tag_vld_d[0] = grant_vld;
    tag_ch_d[0]  = grant_ch;
    for (int s = 1; s < MEM_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_ch_d[s]  = tag_ch_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdy_q <= '0;
      inflight_q <= '0;
      abort_q    <= '0;
      data_q     <= '0;
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) tag_ch_q[s] <= '0;
    end else begin
      data_rdy_q <= data_rdy_d;
      inflight_q <= inflight_d;
      abort_q    <= abort_d;
      data_q     <= data_d;
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      for (int s = 0; s < MEM_LATENCY; s++) tag_ch_q[s] <= tag_ch_d[s];
    end
  end

  assign data     = data_q;
  assign data_rdy = data_rdy_q;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8: number of requester channels, legal range 1..32.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8: memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: memory data width.
REQ-004 SHALL have parameter MEM_LATENCY, default 1: cycles from address issue to mem_data valid, legal range 1..8.
REQ-005 SHALL have parameter PRIORITY_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port data_req, input, NUM_CHANNELS bits: per-channel read request level.
REQ-009 SHALL have port data_addr, input, NUM_CHANNELS*ADDRESS_WIDTH bits: channel i address at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-010 SHALL have port data, output, NUM_CHANNELS*DATA_WIDTH bits: channel i read data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port data_rdy, output, NUM_CHANNELS bits: per-channel data-valid flag.
REQ-012 SHALL have port mem_data_addr, output, ADDRESS_WIDTH bits: memory read address.
REQ-013 SHALL have port mem_rd_en, output, 1 bit: memory read strobe.
REQ-014 SHALL have port mem_data, input, DATA_WIDTH bits: memory read data.

Function
REQ-015 SHALL define channel i as eligible when data_req[i]=1, data_rdy[i]=0 and inflight[i]=0.
REQ-016 SHALL compute the grant combinationally each cycle, with at most one eligible channel granted per cycle.
REQ-017 SHALL, with PRIORITY_MODE=0, grant the lowest-index eligible channel.
REQ-018 SHALL, with PRIORITY_MODE=1, grant the first eligible channel searching cyclically upward from rr_ptr; after each grant to channel g, rr_ptr SHALL become (g+1) mod NUM_CHANNELS.
REQ-019 SHALL, in a cycle with a grant, drive mem_data_addr with the granted channel's data_addr and mem_rd_en=1; otherwise mem_data_addr=0 and mem_rd_en=0.
REQ-020 SHALL, at the edge ending a grant cycle, set inflight[g] and push {valid, g} into a tag pipeline MEM_LATENCY stages deep.
REQ-021 SHALL treat mem_data as valid in the cycle exactly MEM_LATENCY cycles after the issue cycle, and capture it at the edge ending that cycle into data[g] while setting data_rdy[g]=1 and clearing inflight[g].
REQ-022 SHALL give a latency from an uncontended data_req rise (sampled at edge t) to data_rdy=1 of MEM_LATENCY+1 edges.
REQ-023 SHALL sustain one issue per cycle across channels; each channel has at most one read in flight.
REQ-024 SHALL hold data_rdy[i]=1 and data[i] stable while data_req[i] stays 1.
REQ-025 SHALL clear data_rdy[i] at the first edge where data_req[i]=0; data[i] keeps its last value.
REQ-026 SHALL set abort[i] when data_req[i]=0 while inflight[i]=1; the matching return SHALL then be discarded (data[i] and data_rdy[i] unchanged), and inflight[i] and abort[i] cleared; the channel becomes eligible again on the following cycle.
REQ-027 SHALL keep data_addr[i] stable while data_req[i]=1 as a requester obligation; the block does not re-check the address.
REQ-028 SHALL, with NUM_CHANNELS=1, degenerate to a single-channel pipelined reader with rr_ptr constant 0.

Reset
REQ-029 SHALL, while rst=1 at an edge, clear data, data_rdy, inflight, abort, rr_ptr and all tag-pipeline valid bits to 0.
REQ-030 SHALL drive mem_rd_en=0 and mem_data_addr=0 during any cycle with rst=1.
REQ-031 SHALL discard memory returns for reads issued before a reset edge.

Verification
REQ-032 Single request: MEM_LATENCY=2, req[3]=1, addr=0x21, mem[0x21]=0x5A -> mem_rd_en with addr 0x21 in the same cycle; data_rdy[3]=1 with data=0x5A after 3 edges; rdy falls 1 edge after req drops.
REQ-033 Round-robin: PRIORITY_MODE=1, req[0], req[1] and req[2] held and re-requested continuously -> grant order 0,1,2,0,1,2; no channel is starved.
REQ-034 Fixed priority: PRIORITY_MODE=0, req[5] and req[2] rise together -> channel 2 issued first and channel 5 the next cycle; rdy[2] precedes rdy[5] by 1 cycle.
REQ-035 Abort: MEM_LATENCY=3, req[4] drops 1 cycle after issue -> no data_rdy[4], data[4] unchanged; when req[4] re-rises, a new issue occurs only after the stale return has retired.
REQ-036 Reset mid-flight: rst asserted with 3 reads in flight -> all outputs 0 after the edge; no data_rdy asserts from pre-reset returns.
REQ-037 Back-to-back: all 8 channels request simultaneously with MEM_LATENCY=1 -> 8 consecutive mem_rd_en cycles; each channel receives its own address's data.
